// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, error codes,
// controller states and the alignment rule.
package lsu_pkg;

  localparam int TIMEOUT_DEF = 15;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_BOTH    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  function automatic logic size_ok(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic ok;
    unique case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      SZ_ILL:  ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend from a memory word, and
// store replication plus byte-enable generation.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  ld_size_i,
  input  logic        ld_uns_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o,
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{ld_off_i, 3'b000} +: 8];
    h = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ldata_o = rdata_i;
    unique case (1'b1)
      (ld_size_i == SZ_BYTE):
        ldata_o = {{24{~ld_uns_i & b[7]}}, b};
      (ld_size_i == SZ_HALF):
        ldata_o = {{16{~ld_uns_i & h[15]}}, h};
      default:
        ldata_o = rdata_i;
    endcase
  end

  always_comb begin
    wdata_o = sdata_i;
    be_o    = 4'hF;
    unique case (1'b1)
      (st_size_i == SZ_BYTE): begin
        wdata_o = {4{sdata_i[7:0]}};
        be_o    = 4'b0001 << st_off_i;
      end
      (st_size_i == SZ_HALF): begin
        wdata_o = {2{sdata_i[15:0]}};
        be_o    = 4'b0011 << st_off_i;
      end
      default: begin
        wdata_o = sdata_i;
        be_o    = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access to a word memory with
// ready handshake, lane alignment, error strobes and wait timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] AlUResult,
  input  logic [31:0] ReadData2,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic [1:0]  ErrCode,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          accept, fin_ok, fin_to;

  logic          rd_q, wr_q, vld_q, ld_q, uns_q;
  logic [1:0]    size_q, off_q;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q, ldata_q;
  logic [3:0]    be_q;

  logic [31:0]   ld_ext, st_wdata;
  logic [3:0]    st_be;
  logic          req, both;

  assign req  = MemRead | MemWrite;
  assign both = MemRead & MemWrite;

  lsu_align u_align (
    .ld_size_i (size_q),
    .ld_uns_i  (uns_q),
    .ld_off_i  (off_q),
    .rdata_i   (mem_rdata),
    .ldata_o   (ld_ext),
    .st_size_i (Size),
    .st_off_i  (AlUResult[1:0]),
    .sdata_i   (ReadData2),
    .wdata_o   (st_wdata),
    .be_o      (st_be)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = ERR_NONE;
    accept  = 1'b0;
    fin_ok  = 1'b0;
    fin_to  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (both) begin
          err_d = ERR_BOTH;
        end else if (req && !size_ok(Size, AlUResult[1:0])) begin
          err_d = ERR_ALIGN;
        end else if (req) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          fin_ok  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == LAST) begin
          fin_to  = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is gated by reset so every output is quiet while held in reset
  assign Stall = Reset_n & (accept | (state_q == S_ACCESS));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      vld_q   <= 1'b0;
      ldata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ld_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= fin_ok & ld_q;
      if (accept) begin
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        addr_q  <= AlUResult[31:2];
        wdata_q <= st_wdata;
        be_q    <= MemWrite ? st_be : 4'hF;
        ld_q    <= MemRead;
        uns_q   <= Unsigned;
        size_q  <= Size;
        off_q   <= AlUResult[1:0];
      end else if (fin_ok | fin_to) begin
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        be_q    <= '0;
      end
      if (fin_ok & ld_q) begin
        ldata_q <= ld_ext;
      end else if (fin_to) begin
        ldata_q <= '0;
      end
    end
  end

  assign LoadData  = ldata_q;
  assign LoadValid = vld_q;
  assign ErrCode   = err_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule
